// File: rtl/seg7_display_ctrl.sv
// seg7_display_ctrl: DIGITS-wide hex/BCD value register driving seven-segment digits with lzb and blink.
// Optional multiplexed scan output when SEG7_SCAN_EN is defined; otherwise all digits are driven statically.
module seg7_display_ctrl #(
  parameter int DIGITS     = 8,
  parameter int RADIX      = 16,
  parameter int BLINK_DIV  = 24,
  parameter int SCAN_DIV   = 16,
  parameter bit ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] din,
  input  logic                inc,
  input  logic [DIGITS-1:0]   blink_mask,
  input  logic                lzb,
  output logic [4*DIGITS-1:0] value,
  output logic                wrap,
  output logic [7*DIGITS-1:0] seg,
  output logic [DIGITS-1:0]   dig_sel
);
  localparam logic [6:0] BLANK = {7{ACTIVE_LOW}};

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'h0: enc = 7'h3F;
      4'h1: enc = 7'h06;
      4'h2: enc = 7'h5B;
      4'h3: enc = 7'h4F;
      4'h4: enc = 7'h66;
      4'h5: enc = 7'h6D;
      4'h6: enc = 7'h7D;
      4'h7: enc = 7'h07;
      4'h8: enc = 7'h7F;
      4'h9: enc = 7'h6F;
      4'hA: enc = 7'h77;
      4'hB: enc = 7'h7C;
      4'hC: enc = 7'h39;
      4'hD: enc = 7'h5E;
      4'hE: enc = 7'h79;
      default: enc = 7'h71;
    endcase
  endfunction

  // Illegal BCD digits (>9) count as 9 so they clear and carry.
  function automatic logic is_max(input logic [3:0] d);
    return (RADIX == 10) ? (d >= 4'd9) : (d == 4'hF);
  endfunction

  logic [4*DIGITS-1:0] r_value, w_inc_value;
  logic                r_wrap, w_carry;
  logic [BLINK_DIV-1:0] r_blink_cnt;
  logic [7*DIGITS-1:0] r_seg, w_pat;
  logic [DIGITS:0]     w_upper_zero;

  always_comb begin
    w_inc_value = r_value;
    w_carry = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (w_carry) w_inc_value[4*k+:4] = is_max(r_value[4*k+:4]) ? 4'd0 : r_value[4*k+:4] + 4'd1;
      w_carry = w_carry & is_max(r_value[4*k+:4]);
    end
  end

  always_comb begin
    w_upper_zero = '0;
    w_upper_zero[DIGITS] = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) w_upper_zero[k] = w_upper_zero[k+1] & (r_value[4*k+:4] == 4'd0);
    w_pat = '0;
    for (int k = 0; k < DIGITS; k++)
      w_pat[7*k+:7] = ((lzb && k != 0 && w_upper_zero[k]) || (blink_mask[k] && r_blink_cnt[BLINK_DIV-1]))
                      ? BLANK : enc(r_value[4*k+:4]) ^ {7{ACTIVE_LOW}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value     <= '0;
      r_wrap      <= 1'b0;
      r_blink_cnt <= '0;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
      r_wrap      <= !load && inc && w_carry;
      if (load) r_value <= din;
      else if (inc) r_value <= w_inc_value;
    end
  end

`ifdef SEG7_SCAN_EN
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [SW-1:0]       r_scan_cnt;
  logic [IW-1:0]       r_scan_idx, w_idx_next;
  logic [DIGITS-1:0]   r_dig_sel;
  logic [7*DIGITS-1:0] w_seg_next;
  logic                w_step;

  assign w_step     = r_scan_cnt == SW'(SCAN_DIV - 1);
  assign w_idx_next = !w_step ? r_scan_idx : (r_scan_idx == IW'(DIGITS - 1)) ? '0 : r_scan_idx + 1'b1;

  // Pattern follows the next index so seg and dig_sel switch together.
  always_comb begin
    w_seg_next = {DIGITS{BLANK}};
    w_seg_next[6:0] = w_pat[7*w_idx_next+:7];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan_cnt <= '0;
      r_scan_idx <= '0;
      r_dig_sel  <= DIGITS'(1);
      r_seg      <= {DIGITS{BLANK}};
    end else begin
      r_scan_cnt <= w_step ? '0 : r_scan_cnt + 1'b1;
      r_scan_idx <= w_idx_next;
      r_dig_sel  <= DIGITS'(1) << w_idx_next;
      r_seg      <= w_seg_next;
    end
  end

  assign dig_sel = r_dig_sel;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_seg <= {DIGITS{BLANK}};
    else r_seg <= w_pat;
  end

  assign dig_sel = '1;
`endif

  assign value = r_value;
  assign wrap  = r_wrap;
  assign seg   = r_seg;
endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb_seg7_display_ctrl: hex (active-high) and BCD (active-low) instances checked against a behavioural model.
module tb_seg7_display_ctrl;
  logic        clk = 1'b0;
  logic        reset, load, inc, lzb;
  logic [15:0] din;
  logic [3:0]  blink_mask;
  logic [15:0] hex_val, bcd_val;
  logic        hex_wrap, bcd_wrap;
  logic [27:0] hex_seg, bcd_seg;
  logic [3:0]  hex_sel, bcd_sel;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  seg7_display_ctrl #(.DIGITS(4), .RADIX(16), .BLINK_DIV(4), .SCAN_DIV(2), .ACTIVE_LOW(0)) u_hex (
    .clk(clk), .reset(reset), .load(load), .din(din), .inc(inc), .blink_mask(blink_mask), .lzb(lzb),
    .value(hex_val), .wrap(hex_wrap), .seg(hex_seg), .dig_sel(hex_sel));

  seg7_display_ctrl #(.DIGITS(4), .RADIX(10), .BLINK_DIV(4), .SCAN_DIV(2), .ACTIVE_LOW(1)) u_bcd (
    .clk(clk), .reset(reset), .load(load), .din(din), .inc(inc), .blink_mask(blink_mask), .lzb(lzb),
    .value(bcd_val), .wrap(bcd_wrap), .seg(bcd_seg), .dig_sel(bcd_sel));

  logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [27:0] pats(input logic [15:0] v, input logic lz, input logic [3:0] msk,
                                       input logic ph, input logic al);
    logic [27:0] r;
    for (int k = 0; k < 4; k++) begin
      logic [6:0] p;
      p = ((lz && k > 0 && (v >> (4 * k)) == 16'h0) || (msk[k] && ph)) ? 7'h00 : lut[v[4*k+:4]];
      r[7*k+:7] = al ? ~p : p;
    end
    return r;
  endfunction

  function automatic logic [27:0] pick(input logic [27:0] full, input int idx, input logic al);
    logic [27:0] r;
    r = al ? 28'hFFFFFFF : 28'h0;
    r[6:0] = full[7*idx+:7];
    return r;
  endfunction

  // Lowest digit below 9 gets +1, everything beneath it clears; none found means rollover.
  function automatic logic [16:0] bcd_inc(input logic [15:0] v);
    for (int p = 0; p < 4; p++)
      if (v[4*p+:4] < 4'd9) begin
        logic [15:0] keep;
        keep = 16'hFFFF << (4 * p + 4);
        return {1'b0, (v & keep) | (16'(v[4*p+:4] + 4'd1) << (4 * p))};
      end
    return 17'h10000;
  endfunction

  logic [15:0] m_hv, m_bv;
  logic        m_hw, m_bw, m_ph;
  logic [27:0] m_hs, m_bs, m_hp, m_bp;
  logic [3:0]  m_ds;
  int          m_cyc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hv = 0; m_bv = 0; m_hw = 0; m_bw = 0; m_cyc = 0;
      m_hs = 28'h0; m_bs = 28'hFFFFFFF;
`ifdef SEG7_SCAN_EN
      m_ds = 4'b0001;
`else
      m_ds = 4'b1111;
`endif
    end else begin
      m_ph = m_cyc[3];
      m_hp = pats(m_hv, lzb, blink_mask, m_ph, 1'b0);
      m_bp = pats(m_bv, lzb, blink_mask, m_ph, 1'b1);
      m_cyc++;
`ifdef SEG7_SCAN_EN
      m_ds = 4'b0001 << ((m_cyc / 2) % 4);
      m_hs = pick(m_hp, (m_cyc / 2) % 4, 1'b0);
      m_bs = pick(m_bp, (m_cyc / 2) % 4, 1'b1);
`else
      m_hs = m_hp;
      m_bs = m_bp;
`endif
      if (load) begin
        m_hv = din; m_bv = din; m_hw = 0; m_bw = 0;
      end else if (inc) begin
        {m_hw, m_hv} = {1'b0, m_hv} + 17'd1;
        {m_bw, m_bv} = bcd_inc(m_bv);
      end else begin
        m_hw = 0; m_bw = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("hex_val", 32'(hex_val), 32'(m_hv));
    check("hex_wrap", 32'(hex_wrap), 32'(m_hw));
    check("hex_seg", 32'(hex_seg), 32'(m_hs));
    check("hex_sel", 32'(hex_sel), 32'(m_ds));
    check("bcd_val", 32'(bcd_val), 32'(m_bv));
    check("bcd_wrap", 32'(bcd_wrap), 32'(m_bw));
    check("bcd_seg", 32'(bcd_seg), 32'(m_bs));
    check("bcd_sel", 32'(bcd_sel), 32'(m_ds));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int n_blank;
    reset = 1; load = 0; inc = 0; din = 0; blink_mask = 0; lzb = 0;
    repeat (2) @(negedge clk);
    check("rst_val", 32'(hex_val), 32'h0);
    check("rst_wrap", 32'(hex_wrap), 32'h0);
    check("rst_hex_seg", 32'(hex_seg), 32'h0);
    check("rst_bcd_seg", 32'(bcd_seg), 32'hFFFFFFF);
`ifdef SEG7_SCAN_EN
    check("rst_sel", 32'(hex_sel), 32'h1);
`else
    check("rst_sel", 32'(hex_sel), 32'hF);
`endif
    reset = 0;
    load = 1; din = 16'h12AF;
    tick();
    load = 0;
    check("load_val", 32'(hex_val), 32'h12AF);
    tick();
`ifndef SEG7_SCAN_EN
    check("load_seg", 32'(hex_seg), 32'({7'h06, 7'h5B, 7'h77, 7'h71}));
`endif
    load = 1; din = 16'h0999; tick();
    load = 0; inc = 1; tick();
    inc = 0;
    check("bcd_carry", 32'(bcd_val), 32'h1000);
    check("bcd_carry_wrap", 32'(bcd_wrap), 32'h0);
    load = 1; din = 16'h9999; tick();
    load = 0; inc = 1; tick();
    inc = 0;
    check("bcd_roll", 32'(bcd_val), 32'h0);
    check("bcd_roll_wrap", 32'(bcd_wrap), 32'h1);
    tick();
    check("bcd_wrap_pulse", 32'(bcd_wrap), 32'h0);
    load = 1; inc = 1; din = 16'h0005; tick();
    load = 0; inc = 0;
    check("load_inc_hex", 32'(hex_val), 32'h5);
    check("load_inc_bcd", 32'(bcd_val), 32'h5);
    lzb = 1; load = 1; din = 16'h0040; tick();
    load = 0; tick();
`ifndef SEG7_SCAN_EN
    check("lzb_40", 32'(hex_seg), 32'({7'h00, 7'h00, 7'h66, 7'h3F}));
`endif
    load = 1; din = 16'h0000; tick();
    load = 0; tick();
`ifndef SEG7_SCAN_EN
    check("lzb_0", 32'(hex_seg), 32'({7'h00, 7'h00, 7'h00, 7'h3F}));
`endif
    lzb = 0; blink_mask = 4'b0001; load = 1; din = 16'h1234; tick();
    load = 0; tick();
`ifndef SEG7_SCAN_EN
    n_blank = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (hex_seg[6:0] == 7'h00) n_blank++;
      check("blink_steady", 32'(hex_seg[27:7]), 32'({7'h06, 7'h5B, 7'h4F}));
    end
    check("blink_count", n_blank, 8);
`else
    blink_mask = 0;
    tick();
    for (int i = 0; i < 8; i++) begin
      logic [6:0] e;
      tick();
      e = hex_sel == 4'b0001 ? 7'h66 : hex_sel == 4'b0010 ? 7'h4F : hex_sel == 4'b0100 ? 7'h5B : 7'h06;
      check("scan_pat", 32'(hex_seg[6:0]), 32'(e));
    end
    #2 reset = 1;
    #1;
    check("scan_rst_sel", 32'(hex_sel), 32'h1);
    check("scan_rst_seg", 32'(hex_seg), 32'h0);
    check("scan_rst_bcd_seg", 32'(bcd_seg), 32'hFFFFFFF);
    @(negedge clk);
    reset = 0;
`endif
    for (int i = 0; i < 400; i++) begin
      load = $urandom_range(0, 3) == 0;
      inc = $urandom_range(0, 1) == 1;
      lzb = 1'($urandom);
      blink_mask = 4'($urandom);
      case ($urandom_range(0, 5))
        0: din = 16'hFFFF;
        1: din = 16'h9999;
        2: din = 16'h9998;
        3: din = 16'($urandom_range(0, 255));
        default: din = 16'($urandom);
      endcase
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
